vbsc_chain: RTL and testbench

- Parametrised virtual boundary-scan chain of NUM_CELLS I/O cells, driven by the Virtual JTAG state strobes in the tck domain.
- Supports BYPASS, SAMPLE/PRELOAD and EXTEST instructions, decoded from the vjtag IR.
- Sits between the vjtag instance and the per-pin IO buffers. Update and capture are fully synchronous to tck, with a clean registered scan path and defined reset state.

---
 rtl/vbsc_chain.sv | 112 +++++++++++
 tb/tb_vbsc_chain.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vbsc_chain.sv
// rtl/vbsc_chain.sv - virtual boundary-scan chain driven by vjtag state strobes
module vbsc_chain #(
  parameter  int NUM_CELLS = 4,
  parameter  int IR_W      = 2,
  localparam int CHAIN_LEN = 3 * NUM_CELLS
) (
  input  logic                 tck,
  input  logic                 trst_n,
  input  logic                 tdi,
  output logic                 tdo,
  input  logic [IR_W-1:0]      ir_in,
  input  logic                 vjtag_cdr,
  input  logic                 vjtag_sdr,
  input  logic                 vjtag_udr,
  input  logic [NUM_CELLS-1:0] pin_in,
  input  logic [NUM_CELLS-1:0] core_oe,
  input  logic [NUM_CELLS-1:0] core_out,
  output logic [NUM_CELLS-1:0] pin_oe,
  output logic [NUM_CELLS-1:0] pin_out,
  output logic [NUM_CELLS-1:0] core_in,
  output logic                 upd_stb
);

  typedef enum logic [1:0] {
    INSTR_BYPASS  = 2'd0,
    INSTR_SAMPLE  = 2'd1,
    INSTR_EXTEST  = 2'd2,
    INSTR_BYPASS3 = 2'd3
  } instr_t;

  logic [CHAIN_LEN-1:0] r_sr;
  logic                 r_byp;
  logic                 r_udr_q;
  logic [NUM_CELLS-1:0] r_upd_in;
  logic [NUM_CELLS-1:0] r_upd_oe;
  logic [NUM_CELLS-1:0] r_upd_out;
  logic                 r_upd_stb;

  instr_t               w_instr;
  logic                 w_is_extest;
  logic                 w_is_bypass;
  logic                 w_udr_rise;

  // Only the two low IR bits select an instruction; wider IRs ignore the rest.
  assign w_instr     = instr_t'(ir_in[1:0]);
  assign w_is_extest = (w_instr == INSTR_EXTEST);
  assign w_is_bypass = (w_instr == INSTR_BYPASS) || (w_instr == INSTR_BYPASS3);
  assign w_udr_rise  = vjtag_udr & ~r_udr_q;

  // Pin mux: EXTEST hands the pins to the update registers, otherwise transparent.
  always_comb begin
    pin_oe  = core_oe;
    pin_out = core_out;
    core_in = pin_in;
    if (w_is_extest) begin
      pin_oe  = r_upd_oe;
      pin_out = r_upd_out;
      core_in = r_upd_in;
    end
  end

  // tdo is quiet outside shift-DR and shows the register the instruction selects.
  always_comb begin
    tdo = 1'b0;
    if (vjtag_sdr) begin
      tdo = w_is_bypass ? r_byp : r_sr[0];
    end
  end

  // Scan path: capture of post-mux pin values has priority over shifting.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      r_sr  <= '0;
      r_byp <= 1'b0;
    end else if (vjtag_cdr) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        r_sr[3*i]   <= pin_in[i];
        r_sr[3*i+1] <= pin_oe[i];
        r_sr[3*i+2] <= pin_out[i];
      end
      r_byp <= 1'b0;
    end else if (vjtag_sdr) begin
      r_sr  <= {tdi, r_sr[CHAIN_LEN-1:1]};
      r_byp <= tdi;
    end
  end

  // Update stage loads once per udr rising edge; BYPASS never touches the pins.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      r_udr_q   <= 1'b0;
      r_upd_in  <= '0;
      r_upd_oe  <= '0;
      r_upd_out <= '0;
      r_upd_stb <= 1'b0;
    end else begin
      r_udr_q   <= vjtag_udr;
      r_upd_stb <= 1'b0;
      if (w_udr_rise && !w_is_bypass) begin
        for (int i = 0; i < NUM_CELLS; i++) begin
          r_upd_in[i]  <= r_sr[3*i];
          r_upd_oe[i]  <= r_sr[3*i+1];
          r_upd_out[i] <= r_sr[3*i+2];
        end
        r_upd_stb <= 1'b1;
      end
    end
  end

  assign upd_stb = r_upd_stb;

endmodule

// File: tb/tb_vbsc_chain.sv
// tb/tb_vbsc_chain.sv - directed self-checking bench for vbsc_chain
module tb_vbsc_chain;

  logic       tck;
  logic       trst_n;
  logic       tdi;
  logic       tdo;
  logic [1:0] ir_in;
  logic       vjtag_cdr;
  logic       vjtag_sdr;
  logic       vjtag_udr;
  logic [3:0] pin_in;
  logic [3:0] core_oe;
  logic [3:0] core_out;
  logic [3:0] pin_oe;
  logic [3:0] pin_out;
  logic [3:0] core_in;
  logic       upd_stb;

  int n_assert;
  int n_fail;
  int stb_count;
  logic [11:0] vec;

  vbsc_chain #(.NUM_CELLS(4), .IR_W(2)) dut (
    .tck      (tck),
    .trst_n   (trst_n),
    .tdi      (tdi),
    .tdo      (tdo),
    .ir_in    (ir_in),
    .vjtag_cdr(vjtag_cdr),
    .vjtag_sdr(vjtag_sdr),
    .vjtag_udr(vjtag_udr),
    .pin_in   (pin_in),
    .core_oe  (core_oe),
    .core_out (core_out),
    .pin_oe   (pin_oe),
    .pin_out  (pin_out),
    .core_in  (core_in),
    .upd_stb  (upd_stb)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  task automatic step();
    @(posedge tck);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shift 12 bits, sr bit 0 first, so that after the last edge sr == v.
  task automatic shift12(input logic [11:0] v);
    vjtag_sdr = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tdi = v[k];
      step();
    end
    vjtag_sdr = 1'b0;
    tdi = 1'b0;
  endtask

  task automatic pulse_udr();
    vjtag_udr = 1'b1;
    step();
    vjtag_udr = 1'b0;
  endtask

  task automatic check_pins(input string tag, input logic [3:0] oe, input logic [3:0] out, input logic [3:0] cin);
    check({tag, "_pin_oe"}, {8'd0, pin_oe}, {8'd0, oe});
    check({tag, "_pin_out"}, {8'd0, pin_out}, {8'd0, out});
    check({tag, "_core_in"}, {8'd0, core_in}, {8'd0, cin});
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    trst_n    = 1'b0;
    tdi       = 1'b0;
    ir_in     = 2'd2;
    vjtag_cdr = 1'b0;
    vjtag_sdr = 1'b0;
    vjtag_udr = 1'b0;
    pin_in    = 4'b0000;
    core_oe   = 4'b0000;
    core_out  = 4'b0000;

    // Reset in EXTEST: update registers cleared, all pins tristated.
    #1;
    check_pins("reset", 4'b0000, 4'b0000, 4'b0000);
    check("reset_tdo", {11'd0, tdo}, 12'd0);
    check("reset_stb", {11'd0, upd_stb}, 12'd0);
    step();
    step();
    trst_n = 1'b1;

    // SAMPLE: capture post-mux pins, then shift out sr[0] first.
    ir_in    = 2'd1;
    pin_in   = 4'b1010;
    core_oe  = 4'b0011;
    core_out = 4'b0101;
    #1;
    check_pins("sample_transparent", 4'b0011, 4'b0101, 4'b1010);
    vjtag_cdr = 1'b1;
    step();
    vjtag_cdr = 1'b0;
    vjtag_sdr = 1'b1;
    // Expected tdo order 0,1,1,1,1,0,0,0,1,1,0,0 packed with first bit at [0].
    vec = 12'b0011_0001_1110;
    for (int k = 0; k < 12; k++) begin
      tdi = 1'b0;
      #1;
      check($sformatf("sample_tdo%0d", k), {11'd0, tdo}, {11'd0, vec[k]});
      step();
    end
    vjtag_sdr = 1'b0;
    #1;
    check("sdr_low_tdo", {11'd0, tdo}, 12'd0);

    // Preload sr = 001_111_010_100 and update in SAMPLE.
    shift12(12'b001_111_010_100);
    vjtag_udr = 1'b1;
    step();
    check("preload_stb_hi", {11'd0, upd_stb}, 12'd1);
    check_pins("preload_transparent", 4'b0011, 4'b0101, 4'b1010);
    vjtag_udr = 1'b0;
    step();
    check("preload_stb_lo", {11'd0, upd_stb}, 12'd0);
    // Cells: c0 in0 oe0 out1, c1 in0 oe1 out0, c2 in1 oe1 out1, c3 in1 oe0 out0.
    ir_in = 2'd2;
    #1;
    check_pins("extest", 4'b0110, 4'b0101, 4'b1100);

    // BYPASS: one-tck delay through byp, cleared by capture.
    ir_in = 2'd0;
    #1;
    check_pins("bypass_transparent", 4'b0011, 4'b0101, 4'b1010);
    vjtag_cdr = 1'b1;
    step();
    vjtag_cdr = 1'b0;
    vjtag_sdr = 1'b1;
    vec = 12'b0000_0000_1101;
    for (int k = 0; k < 4; k++) begin
      tdi = vec[k];
      #1;
      check($sformatf("bypass_tdo%0d", k), {11'd0, tdo}, (k == 0) ? 12'd0 : {11'd0, vec[k-1]});
      step();
    end
    vjtag_sdr = 1'b0;
    tdi = 1'b0;
    vjtag_udr = 1'b1;
    step();
    check("bypass_no_stb", {11'd0, upd_stb}, 12'd0);
    vjtag_udr = 1'b0;
    step();
    check("bypass_no_stb2", {11'd0, upd_stb}, 12'd0);
    ir_in = 2'd2;
    #1;
    check_pins("bypass_upd_kept", 4'b0110, 4'b0101, 4'b1100);

    // EXTEST: udr held 5 tck yields a single update.
    shift12(12'b110_001_101_011);
    check_pins("extest_shift_kept", 4'b0110, 4'b0101, 4'b1100);
    stb_count = 0;
    vjtag_udr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      stb_count += int'(upd_stb);
    end
    vjtag_udr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      stb_count += int'(upd_stb);
    end
    check("held_udr_one_stb", stb_count[11:0], 12'd1);
    // c0 in1 oe1 out0, c1 in1 oe0 out1, c2 in1 oe0 out0, c3 in0 oe1 out1.
    check_pins("held_udr", 4'b1001, 4'b1010, 4'b0111);
    shift12(12'hfff);
    check_pins("held_udr_sr_change", 4'b1001, 4'b1010, 4'b0111);

    // Reset after 6 of 12 shifts clears sr and update registers asynchronously.
    vec = 12'b010_101_110_001;
    vjtag_sdr = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tdi = vec[k];
      step();
    end
    tdi = 1'b0;
    trst_n = 1'b0;
    #1;
    check_pins("midreset", 4'b0000, 4'b0000, 4'b0000);
    check("midreset_tdo", {11'd0, tdo}, 12'd0);
    check("midreset_stb", {11'd0, upd_stb}, 12'd0);
    vjtag_sdr = 1'b0;
    trst_n = 1'b1;
    shift12(vec);
    vjtag_udr = 1'b1;
    step();
    check("post_reset_stb", {11'd0, upd_stb}, 12'd1);
    vjtag_udr = 1'b0;
    // c0 in1 oe0 out0, c1 in0 oe1 out1, c2 in1 oe0 out1, c3 in0 oe1 out0.
    check_pins("post_reset", 4'b1010, 4'b0110, 4'b0101);

    // Leaving EXTEST returns pins to transparent with no tck.
    ir_in = 2'd3;
    #1;
    check_pins("leave_extest", 4'b0011, 4'b0101, 4'b1010);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
